// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: forwarding and load-use hazard controller for the pipelined core.
//
// Shadows the destination-register pipeline (EX, MEM, WB, RET) and produces the
// operand-mux selects for the EX stage, a one-cycle load-use stall, and a
// saturating stall counter for performance debug.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   id_valid   - a valid instruction is in ID
//   id_rs1     - ID source A register
//   id_rs2     - ID source B register
//   id_rd      - ID destination register
//   id_we      - ID instruction writes id_rd
//   id_is_load - ID instruction is a load (result available at WB)
//   flush      - squash the instruction entering EX
//   sel_a      - operand-A select: 0 regfile, 1 MEM, 2 WB, 3 RET
//   sel_b      - operand-B select, same encoding
//   stall      - hold PC and IF/ID, insert a bubble into EX
//   stall_cnt  - saturating count of stall cycles
module fwd_sel_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Slot valid bits and the stall counter are the only reset state; the
  // remaining slot fields are qualified by their valid bit.
  logic                  ex_vld_q,  mem_vld_q,  wb_vld_q,  ret_vld_q;
  logic                  ex_we_q,   mem_we_q,   wb_we_q,   ret_we_q;
  logic                  ex_ld_q,   mem_ld_q;
  logic [REG_ADDR_W-1:0] ex_rd_q,   mem_rd_q,   wb_rd_q,   ret_rd_q;
  logic [REG_ADDR_W-1:0] ex_rs1_q,  ex_rs2_q;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  ex_load_d;
  logic                  ex_vld_d;

  logic mem_hit_a, wb_hit_a, ret_hit_a;
  logic mem_hit_b, wb_hit_b, ret_hit_b;

  function automatic logic slot_writes(input logic                  vld,
                                       input logic                  we,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] r);
    return vld & we & (rd == r) & (r != '0);
  endfunction

  // Youngest producer wins: MEM over WB over RET.
  function automatic logic [1:0] pick_sel(input logic ex_vld,
                                          input logic mem_hit,
                                          input logic wb_hit,
                                          input logic ret_hit);
    if (!ex_vld)       return 2'd0;
    else if (mem_hit)  return 2'd1;
    else if (wb_hit)   return 2'd2;
    else if (ret_hit)  return 2'd3;
    else               return 2'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A load sitting in MEM has no ALU result to forward, so it is excluded
  // from the MEM match; the stall keeps that case from ever arising.
  always_comb begin
    mem_hit_a = slot_writes(mem_vld_q, mem_we_q, mem_rd_q, ex_rs1_q) & ~mem_ld_q;
    wb_hit_a  = slot_writes(wb_vld_q,  wb_we_q,  wb_rd_q,  ex_rs1_q);
    ret_hit_a = slot_writes(ret_vld_q, ret_we_q, ret_rd_q, ex_rs1_q);
    mem_hit_b = slot_writes(mem_vld_q, mem_we_q, mem_rd_q, ex_rs2_q) & ~mem_ld_q;
    wb_hit_b  = slot_writes(wb_vld_q,  wb_we_q,  wb_rd_q,  ex_rs2_q);
    ret_hit_b = slot_writes(ret_vld_q, ret_we_q, ret_rd_q, ex_rs2_q);
  end

  assign sel_a = pick_sel(ex_vld_q, mem_hit_a, wb_hit_a, ret_hit_a);
  assign sel_b = pick_sel(ex_vld_q, mem_hit_b, wb_hit_b, ret_hit_b);

  // Load in EX whose destination is read by the instruction in ID.
  assign ex_load_d = ex_vld_q & ex_we_q & ex_ld_q & (ex_rd_q != '0);
  assign stall     = id_valid & ex_load_d & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  // Stall and flush both turn the EX entry into a bubble.
  assign ex_vld_d    = id_valid & ~stall & ~flush;
  assign stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q    <= 1'b0;
      mem_vld_q   <= 1'b0;
      wb_vld_q    <= 1'b0;
      ret_vld_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_vld_q    <= ex_vld_d;
      mem_vld_q   <= ex_vld_q;
      wb_vld_q    <= mem_vld_q;
      ret_vld_q   <= wb_vld_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ex_rd_q  <= id_rd;
    ex_we_q  <= id_we;
    ex_ld_q  <= id_is_load;
    ex_rs1_q <= id_rs1;
    ex_rs2_q <= id_rs2;
    mem_rd_q <= ex_rd_q;
    mem_we_q <= ex_we_q;
    mem_ld_q <= ex_ld_q;
    wb_rd_q  <= mem_rd_q;
    wb_we_q  <= mem_we_q;
    ret_rd_q <= wb_rd_q;
    ret_we_q <= wb_we_q;
  end

  // A load in MEM must never be the source of the EX instruction.
  mem_load_use_never : assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_vld_q && mem_vld_q && mem_we_q && mem_ld_q && (mem_rd_q != '0) &&
      ((mem_rd_q == ex_rs1_q) || (mem_rd_q == ex_rs2_q))));

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
module tb_fwd_sel_ctrl;
  localparam int AW   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_we = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [1:0]    sel_a, sel_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_sel_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .sel_a(sel_a), .sel_b(sel_b), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  // Reference model: history of instructions by age (0 = EX, 1 = MEM, 2 = WB, 3 = RET).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
    int rs1;
    int rs2;
  } ins_t;

  ins_t pipe [4];
  int   m_cnt = 0;

  function automatic bit produces(ins_t s, int r);
    return s.v && s.we && (s.rd == r) && (r != 0);
  endfunction

  function automatic int m_sel(int r);
    if (!pipe[0].v || r == 0) return 0;
    if (produces(pipe[1], r) && !pipe[1].ld) return 1;
    if (produces(pipe[2], r)) return 2;
    if (produces(pipe[3], r)) return 3;
    return 0;
  endfunction

  function automatic bit m_stall();
    return id_valid && pipe[0].v && pipe[0].we && pipe[0].ld && (pipe[0].rd != 0) &&
           ((pipe[0].rd == int'(id_rs1)) || (pipe[0].rd == int'(id_rs2)));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) pipe[i] = '{default: 0};
    m_cnt = 0;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear();
      end else begin
        bit st;
        st = m_stall();
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        if (!st && !flush)
          pipe[0] = '{v: id_valid, rd: int'(id_rd), we: id_we, ld: id_is_load,
                      rs1: int'(id_rs1), rs2: int'(id_rs2)};
        else
          pipe[0].v = 1'b0;
        if (st && m_cnt < CMAX) m_cnt++;
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_sel_a", int'(sel_a), m_sel(pipe[0].rs1));
      chk("cyc_sel_b", int'(sel_b), m_sel(pipe[0].rs2));
      chk("cyc_stall", int'(stall), int'(m_stall()));
      chk("cyc_stall_cnt", int'(stall_cnt), m_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(bit v, int rs1, int rs2, int rd, bit we, bit ld, bit fl);
    id_valid   = v;
    id_rs1     = AW'(rs1);
    id_rs2     = AW'(rs2);
    id_rd      = AW'(rd);
    id_we      = we;
    id_is_load = ld;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit v, int rs1, int rs2, int rd, bit we, bit ld, bit fl);
    drive(v, rs1, rs2, rd, we, ld, fl);
    tick();
  endtask

  task automatic idle(int n);
    repeat (n) issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_sel_b", int'(sel_b), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_sel_a", int'(sel_a), 0);
    chk("idle_cnt", int'(stall_cnt), 0);

    // Back-to-back ALU forwarding from MEM, WB, RET
    issue(1, 0, 0, 3, 1, 0, 0);
    issue(1, 3, 0, 0, 0, 0, 0);
    chk("b2b_mem", int'(sel_a), 1);
    issue(1, 0, 3, 0, 0, 0, 0);
    chk("b2b_wb", int'(sel_b), 2);
    issue(1, 3, 0, 0, 0, 0, 0);
    chk("b2b_ret", int'(sel_a), 3);
    issue(1, 3, 0, 0, 0, 0, 0);
    chk("b2b_none", int'(sel_a), 0);

    // Priority: youngest producer wins; r0 never forwards
    issue(1, 0, 0, 2, 1, 0, 0);
    issue(1, 0, 0, 2, 1, 0, 0);
    issue(1, 2, 0, 0, 0, 0, 0);
    chk("prio_youngest", int'(sel_a), 1);
    issue(1, 0, 0, 0, 1, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0);
    chk("r0_sel_a", int'(sel_a), 0);
    idle(3);

    // Load-use: one stall cycle, bubble, then forward from WB
    issue(1, 0, 0, 5, 1, 1, 0);
    drive(1, 0, 5, 6, 1, 0, 0);
    #1;
    chk("lu_stall", int'(stall), 1);
    tick();
    chk("lu_bubble_sel_b", int'(sel_b), 0);
    chk("lu_stall_drop", int'(stall), 0);
    chk("lu_cnt", int'(stall_cnt), 1);
    tick();
    chk("lu_fwd_wb", int'(sel_b), 2);
    idle(3);

    // Flush together with stall
    issue(1, 0, 0, 4, 1, 1, 0);
    drive(1, 4, 0, 0, 0, 0, 1);
    #1;
    chk("fl_stall", int'(stall), 1);
    tick();
    chk("fl_bubble_sel_a", int'(sel_a), 0);
    chk("fl_cnt", int'(stall_cnt), 2);
    idle(3);

    // Asynchronous reset with three valid slots in flight
    issue(1, 0, 0, 1, 1, 0, 0);
    issue(1, 0, 0, 2, 1, 0, 0);
    issue(1, 1, 2, 3, 1, 0, 0);
    chk("pre_rst_sel_a", int'(sel_a), 2);
    chk("pre_rst_sel_b", int'(sel_b), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel_a", int'(sel_a), 0);
    chk("arst_sel_b", int'(sel_b), 0);
    chk("arst_cnt", int'(stall_cnt), 0);
    #3;
    rst_n = 1'b1;
    tick();

    // Saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      issue(1, 0, 0, 5, 1, 1, 0);
      drive(1, 0, 5, 0, 0, 0, 0);
      tick();
      tick();
      if (i == 14) chk("sat_reach", int'(stall_cnt), CMAX);
    end
    chk("sat_hold", int'(stall_cnt), 15);
    idle(2);
    chk("sat_idle", int'(stall_cnt), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
